noc_port_scheduler: RTL and testbench

//  Output-port scheduler for one router port. Arbitrates round-robin between up
//  to NUM_REQ packet holders whose packets target this port, then serialises the

---
 rtl/RouterPkg.sv | 27 ++
 rtl/noc_rr_picker.sv | 56 +++++
 rtl/noc_port_scheduler.sv | 141 ++++++++++++++
 tb/tb_noc_port_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/RouterPkg.sv
// RouterPkg: shared router types for the output-port scheduler.
//   pkt_t         32-bit packet {src[31:28], dest[27:24], data[23:0]}
//   sched_state_t scheduler FSM states IDLE / WAIT_FREE / SEND
//   PKT_BEATS     bytes per packet on the 8-bit node link
//   idx_width()   width of an index into n requesters (min 1 bit)
package RouterPkg;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FREE = 2'd1,
    SEND      = 2'd2
  } sched_state_t;

  localparam int PKT_BEATS = 4;
  localparam int BEAT_W    = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// noc_rr_picker: combinational round-robin selector.
// Ports:
//   req            in   NUM_REQ  request vector
//   last_grant     in   IDX_W    index granted most recently
//   winner_onehot  out  NUM_REQ  one-hot winner (all zero when no request)
//   winner_idx     out  IDX_W    winner index (0 when no request)
//   any            out  1        at least one request is set
// Priority starts at last_grant+1 and walks upward modulo NUM_REQ.
module noc_rr_picker
  import RouterPkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  // One extra bit so last_grant + offset cannot overflow before the modulo.
  localparam int SW = IDX_W + 1;

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  // cand_idx[gi] is the requester examined at priority position gi.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum          = {1'b0, last_grant} + SW'(gi + 1);
    assign cand_idx[gi] = (sum >= SW'(NUM_REQ)) ? IDX_W'(sum - SW'(NUM_REQ))
                                                : sum[IDX_W-1:0];
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    winner_idx = '0;
    any        = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        winner_idx = cand_idx[k];
        any        = 1'b1;
      end
    end
  end

  always_comb begin
    winner_onehot = '0;
    if (any) begin
      winner_onehot[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/noc_port_scheduler.sv
// noc_port_scheduler: output-port scheduler for one router port.
// Arbitrates round-robin between NUM_REQ packet holders, latches the winning
// 32-bit packet and serialises it MSB-first as four bytes on the node link.
// Ports:
//   clock             in   1                system clock
//   reset             in   1                synchronous active-high reset
//   req               in   NUM_REQ          holder i has a packet for this port
//   req_pkt           in   NUM_REQ x PKT_W  packet offered by holder i
//   free_outbound     in   1                downstream can take a whole packet
//   grant             out  NUM_REQ          one-cycle one-hot release of holder i
//   put_outbound      out  1                payload_outbound byte valid
//   payload_outbound  out  8                serialised packet byte
//   busy              out  1                a packet is owned (WAIT_FREE/SEND)
//   pkt_count         out  16               fully sent packets, wrapping
// Build option: define NOC_SCHED_STATS_EN to add pkt_count and its counter.
module noc_port_scheduler
  import RouterPkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PKT_W   = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][PKT_W-1:0]   req_pkt,
  input  logic                            free_outbound,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            put_outbound,
  output logic [7:0]                      payload_outbound,
  output logic                            busy
`ifdef NOC_SCHED_STATS_EN
  ,
  output logic [15:0]                     pkt_count
`endif
);

  localparam int               IDX_W     = idx_width(NUM_REQ);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  sched_state_t       state_reg;
  logic [IDX_W-1:0]   last_grant_reg;
  pkt_t               pkt_reg;
  logic [BEAT_W-1:0]  beat_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic               put_reg;
  logic [7:0]         payload_reg;
  logic               busy_reg;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  noc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req           (req),
    .last_grant    (last_grant_reg),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .any           (pick_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);   // req[0] gets first priority
      pkt_reg        <= '0;
      beat_reg       <= '0;
      grant_reg      <= '0;
      put_reg        <= 1'b0;
      payload_reg    <= '0;
      busy_reg       <= 1'b0;
    end else begin
      // grant is a single-cycle pulse; only the IDLE branch raises it.
      grant_reg <= '0;
      case (state_reg)
        IDLE: begin
          put_reg <= 1'b0;
          if (pick_any) begin
            pkt_reg        <= pkt_t'(req_pkt[pick_idx]);
            grant_reg      <= pick_onehot;
            last_grant_reg <= pick_idx;
            busy_reg       <= 1'b1;
            state_reg      <= WAIT_FREE;
          end
        end
        WAIT_FREE: begin
          if (free_outbound) begin
            put_reg     <= 1'b1;
            payload_reg <= {pkt_reg.src, pkt_reg.dest};
            beat_reg    <= BEAT_W'(1);
            state_reg   <= SEND;
          end else begin
            put_reg <= 1'b0;
          end
        end
        SEND: begin
          // free_outbound already promised room for the whole packet.
          put_reg  <= 1'b1;
          beat_reg <= beat_reg + BEAT_W'(1);
          case (beat_reg)
            BEAT_W'(1): payload_reg <= pkt_reg.data[23:16];
            BEAT_W'(2): payload_reg <= pkt_reg.data[15:8];
            default:    payload_reg <= pkt_reg.data[7:0];
          endcase
          if (beat_reg == LAST_BEAT) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          put_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef NOC_SCHED_STATS_EN
  logic [15:0] pkt_count_reg;

  // Counts only packets whose last byte went out; truncated ones are not seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_reg <= '0;
    end else if (state_reg == SEND && beat_reg == LAST_BEAT) begin
      pkt_count_reg <= pkt_count_reg + 16'd1;
    end
  end

  assign pkt_count = pkt_count_reg;
`endif

  assign grant            = grant_reg;
  assign put_outbound     = put_reg;
  assign payload_outbound = payload_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_noc_port_scheduler.sv
// Bench for noc_port_scheduler: a per-cycle vector table for the basic send
// and free-stall cases, then directed sequences for round-robin order,
// priority after a grant, reset mid-packet and (when built in) pkt_count.
module tb_noc_port_scheduler;

  logic             clock;
  logic             reset;
  logic [2:0]       req;
  logic [2:0][31:0] req_pkt;
  logic             free_outbound;
  logic [2:0]       grant;
  logic             put_outbound;
  logic [7:0]       payload_outbound;
  logic             busy;
`ifdef NOC_SCHED_STATS_EN
  logic [15:0]      pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] P0 = 32'h12AB_CDEF;
  localparam logic [31:0] P1 = 32'h3456_789A;
  localparam logic [31:0] P2 = 32'hBCDE_F012;

  noc_port_scheduler #(
    .NUM_REQ (3),
    .PKT_W   (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_pkt          (req_pkt),
    .free_outbound    (free_outbound),
    .grant            (grant),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .busy             (busy)
`ifdef NOC_SCHED_STATS_EN
    ,
    .pkt_count        (pkt_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [2:0] req;
    logic       free;
    logic [2:0] exp_grant;
    logic       exp_put;
    logic [7:0] exp_pay;    // compared only while exp_put is 1
    logic       exp_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req           = '0;
    free_outbound = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for a grant, checks it, re-drives req, then checks the
  // four bytes of the packet. free_outbound must already be 1.
  task automatic run_packet(input string name, input logic [2:0] exp_grant,
                            input logic [31:0] pkt, input logic [2:0] next_req);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == 3'b000 && n < 20);
    chk({name, " grant"}, grant, exp_grant);
    req = next_req;
    tick();
    chk({name, " grant pulse"}, grant, 3'b000);
    chk({name, " put b0"}, put_outbound, 1'b1);
    chk({name, " byte0"}, payload_outbound, pkt[31:24]);
    tick();
    chk({name, " put b1"}, put_outbound, 1'b1);
    chk({name, " byte1"}, payload_outbound, pkt[23:16]);
    tick();
    chk({name, " put b2"}, put_outbound, 1'b1);
    chk({name, " byte2"}, payload_outbound, pkt[15:8]);
    tick();
    chk({name, " put b3"}, put_outbound, 1'b1);
    chk({name, " byte3"}, payload_outbound, pkt[7:0]);
    chk({name, " busy end"}, busy, 1'b0);
    $display("packet %s grant=%b bytes=%h", name, exp_grant, pkt);
  endtask

  initial begin
    // Send P0 with free high, then P0 again with free held low for 5 cycles
    // (free also dropped during SEND, which must not matter).
    vecs[0]  = '{3'b001, 1'b1, 3'b001, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{3'b000, 1'b1, 3'b000, 1'b1, 8'h12, 1'b1};
    vecs[2]  = '{3'b000, 1'b1, 3'b000, 1'b1, 8'hAB, 1'b1};
    vecs[3]  = '{3'b000, 1'b1, 3'b000, 1'b1, 8'hCD, 1'b1};
    vecs[4]  = '{3'b000, 1'b1, 3'b000, 1'b1, 8'hEF, 1'b0};
    vecs[5]  = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{3'b001, 1'b0, 3'b001, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1};
    vecs[9]  = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{3'b000, 1'b1, 3'b000, 1'b1, 8'h12, 1'b1};
    vecs[13] = '{3'b000, 1'b0, 3'b000, 1'b1, 8'hAB, 1'b1};
    vecs[14] = '{3'b000, 1'b0, 3'b000, 1'b1, 8'hCD, 1'b1};
    vecs[15] = '{3'b000, 1'b0, 3'b000, 1'b1, 8'hEF, 1'b0};
    vecs[16] = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0};

    req_pkt[0] = P0;
    req_pkt[1] = P1;
    req_pkt[2] = P2;

    // Reset state.
    do_reset();
    chk("reset grant", grant, 3'b000);
    chk("reset put", put_outbound, 1'b0);
    chk("reset payload", payload_outbound, 8'h00);
    chk("reset busy", busy, 1'b0);
`ifdef NOC_SCHED_STATS_EN
    chk("reset pkt_count", pkt_count, 16'd0);
`endif

    // Table-driven single packets.
    for (int i = 0; i < 17; i++) begin
      req           = vecs[i].req;
      free_outbound = vecs[i].free;
      tick();
      $display("vec %0d req=%b free=%b grant=%b put=%b payload=%h busy=%b",
               i, vecs[i].req, vecs[i].free, grant, put_outbound, payload_outbound, busy);
      chk($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
      chk($sformatf("vec%0d put", i), put_outbound, vecs[i].exp_put);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_put) begin
        chk($sformatf("vec%0d payload", i), payload_outbound, vecs[i].exp_pay);
      end
    end

    // Round-robin with all three holders requesting continuously.
    do_reset();
    req           = 3'b111;
    free_outbound = 1'b1;
    for (int r = 0; r < 2; r++) begin
      run_packet($sformatf("rr%0d_h0", r), 3'b001, P0, 3'b111);
      run_packet($sformatf("rr%0d_h1", r), 3'b010, P1, 3'b111);
      run_packet($sformatf("rr%0d_h2", r), 3'b100, P2, 3'b111);
    end

    // After holder 0 is served, 101 must go to holder 2 before holder 0.
    do_reset();
    req           = 3'b001;
    free_outbound = 1'b1;
    run_packet("prio_h0", 3'b001, P0, 3'b101);
    run_packet("prio_h2", 3'b100, P2, 3'b001);
    run_packet("prio_h0b", 3'b001, P0, 3'b000);

    // Reset for two cycles while SEND is on beat 2.
    do_reset();
    req           = 3'b001;
    free_outbound = 1'b1;
    tick();                      // grant
    req = 3'b000;
    tick();                      // byte 0
    tick();                      // byte 1, beat now 2
    chk("trunc pre byte1", payload_outbound, 8'hAB);
    reset = 1'b1;
    tick();
    chk("trunc put", put_outbound, 1'b0);
    chk("trunc payload", payload_outbound, 8'h00);
    chk("trunc grant", grant, 3'b000);
    chk("trunc busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("trunc idle put %0d", i), put_outbound, 1'b0);
    end
    $display("truncation sequence done");

`ifdef NOC_SCHED_STATS_EN
    // Three full packets, then reset while the fourth is on the link.
    do_reset();
    req           = 3'b001;
    free_outbound = 1'b1;
    run_packet("stat1", 3'b001, P0, 3'b001);
    chk("stat count 1", pkt_count, 16'd1);
    run_packet("stat2", 3'b001, P0, 3'b001);
    run_packet("stat3", 3'b001, P0, 3'b001);
    tick();                      // grant of 4th
    req = 3'b000;
    tick();                      // byte 0 of 4th
    chk("stat count 3", pkt_count, 16'd3);
    reset = 1'b1;
    tick();
    chk("stat count cleared", pkt_count, 16'd0);
    reset = 1'b0;
    tick();
    $display("stats sequence done");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
